// File: rtl/regex_stream_driver_if.sv
// Bundles the three handshakes around the regex driver: upstream chars,
// the compiled_regex engine port and the downstream result FIFO head.
interface regex_stream_driver_if #(
  parameter int CHAR_W = 8,
  parameter int POS_W  = 32
);
  logic              in_valid;
  logic [CHAR_W-1:0] in_char;
  logic              in_last;
  logic              in_ready;

  logic              eng_reset;
  logic [CHAR_W-1:0] eng_char;
  logic              eng_last;
  logic              eng_rdy;
  logic              eng_match;
  logic [POS_W-1:0]  eng_start;
  logic [POS_W-1:0]  eng_end;

  logic              res_valid;
  logic              res_ready;
  logic [POS_W-1:0]  res_start;
  logic [POS_W-1:0]  res_end;
  logic              res_last;

  modport master (
    input  in_valid, in_char, in_last, eng_rdy, eng_match, eng_start, eng_end, res_ready,
    output in_ready, eng_reset, eng_char, eng_last, res_valid, res_start, res_end, res_last
  );

  modport slave (
    output in_valid, in_char, in_last, eng_rdy, eng_match, eng_start, eng_end, res_ready,
    input  in_ready, eng_reset, eng_char, eng_last, res_valid, res_start, res_end, res_last
  );
endinterface

// File: rtl/regex_stream_driver.sv
// Sequences one character at a time through a compiled_regex engine and
// queues its (deduplicated) match reports in a small result FIFO.
module regex_stream_driver #(
  parameter int CHAR_W      = 8,
  parameter int POS_W       = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int ENG_RST_CYC = 2,
  parameter int TIMEOUT     = 255,
  parameter int DEDUP       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  regex_stream_driver_if.master bus,
  output logic                  busy_o,
  output logic                  timeout_err_o,
  output logic [POS_W-1:0]      char_count_o
);

  typedef enum logic [2:0] {IDLE, ERST, WAIT, CAPTURE, FIN} state_t;

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int RC_W    = (ENG_RST_CYC > 1) ? $clog2(ENG_RST_CYC) : 1;
  localparam int WD_W    = $clog2(TIMEOUT + 1);
  localparam int ENTRY_W = 2 * POS_W + 1;

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              in_ready_q, in_ready_d;
  logic              eng_reset_q, eng_reset_d;
  logic [CHAR_W-1:0] eng_char_q, eng_char_d;
  logic              eng_last_q, eng_last_d;
  logic              cap_match_q, cap_match_d;
  logic [POS_W-1:0]  cap_start_q, cap_start_d;
  logic [POS_W-1:0]  cap_end_q, cap_end_d;
  logic              hist_valid_q, hist_valid_d;
  logic [POS_W-1:0]  hist_start_q, hist_start_d;
  logic [POS_W-1:0]  hist_end_q, hist_end_d;
  logic              timeout_q, timeout_d;
  logic [POS_W-1:0]  count_q, count_d;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        fcount_q, fcount_d;
  logic               push, pop, full;
  logic [ENTRY_W-1:0] head;

  assign full = (fcount_q == (AW+1)'(FIFO_DEPTH));
  assign pop  = (fcount_q != '0) && bus.res_ready;

  always_comb begin
    state_d      = state_q;
    rcnt_d       = rcnt_q;
    wd_d         = wd_q;
    eng_char_d   = eng_char_q;
    eng_last_d   = eng_last_q;
    cap_match_d  = cap_match_q;
    cap_start_d  = cap_start_q;
    cap_end_d    = cap_end_q;
    hist_valid_d = hist_valid_q;
    hist_start_d = hist_start_q;
    hist_end_d   = hist_end_q;
    timeout_d    = timeout_q;
    count_d      = count_q;
    push         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_ready_q && bus.in_valid) begin
          eng_char_d = bus.in_char;
          eng_last_d = bus.in_last;
          count_d    = count_q + 1'b1;
          rcnt_d     = '0;
          state_d    = ERST;
        end
      end
      ERST: begin
        if (rcnt_q == RC_W'(ENG_RST_CYC - 1)) begin
          wd_d    = '0;
          state_d = WAIT;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (bus.eng_rdy) begin
          cap_match_d = bus.eng_match;
          cap_start_d = bus.eng_start;
          cap_end_d   = bus.eng_end;
          state_d     = CAPTURE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          wd_d      = WD_W'(TIMEOUT);
          timeout_d = 1'b1;
          state_d   = FIN;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      CAPTURE: begin
        // A full FIFO with no pop holds us here, which back-pressures upstream.
        if (!cap_match_q) begin
          state_d = FIN;
        end else if ((DEDUP != 0) && hist_valid_q &&
                     (cap_start_q == hist_start_q) && (cap_end_q == hist_end_q)) begin
          state_d = FIN;
        end else if (!full || pop) begin
          push         = 1'b1;
          hist_valid_d = 1'b1;
          hist_start_d = cap_start_q;
          hist_end_d   = cap_end_q;
          state_d      = FIN;
        end
      end
      FIN: begin
        if (eng_last_q) begin
          count_d      = '0;
          hist_valid_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    eng_reset_d = (state_d == ERST);
  end

  always_comb begin
    fcount_d = fcount_q;
    if (push && !pop) begin
      fcount_d = fcount_q + 1'b1;
    end else if (!push && pop) begin
      fcount_d = fcount_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rcnt_q       <= '0;
      wd_q         <= '0;
      in_ready_q   <= 1'b0;
      eng_reset_q  <= 1'b1;
      eng_char_q   <= '0;
      eng_last_q   <= 1'b0;
      cap_match_q  <= 1'b0;
      cap_start_q  <= '0;
      cap_end_q    <= '0;
      hist_valid_q <= 1'b0;
      hist_start_q <= '0;
      hist_end_q   <= '0;
      timeout_q    <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fcount_q     <= '0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      wd_q         <= wd_d;
      in_ready_q   <= in_ready_d;
      eng_reset_q  <= eng_reset_d;
      eng_char_q   <= eng_char_d;
      eng_last_q   <= eng_last_d;
      cap_match_q  <= cap_match_d;
      cap_start_q  <= cap_start_d;
      cap_end_q    <= cap_end_d;
      hist_valid_q <= hist_valid_d;
      hist_start_q <= hist_start_d;
      hist_end_q   <= hist_end_d;
      timeout_q    <= timeout_d;
      count_q      <= count_d;
      fcount_q     <= fcount_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the head outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {cap_start_q, cap_end_q, eng_last_q};
  end

  assign head          = mem[rd_ptr_q];
  assign bus.res_valid = (fcount_q != '0);
  assign bus.res_start = bus.res_valid ? head[ENTRY_W-1 -: POS_W] : '0;
  assign bus.res_end   = bus.res_valid ? head[POS_W:1] : '0;
  assign bus.res_last  = bus.res_valid ? head[0] : 1'b0;

  assign bus.in_ready  = in_ready_q;
  assign bus.eng_reset = eng_reset_q;
  assign bus.eng_char  = eng_char_q;
  assign bus.eng_last  = eng_last_q;
  assign busy_o        = (state_q != IDLE);
  assign timeout_err_o = timeout_q;
  assign char_count_o  = count_q;

endmodule

// File: tb/tb_regex_stream_driver.sv
// Randomized bench for regex_stream_driver: an engine responder plus a
// transaction-level model of expected results, char counts and timeouts.
module tb_regex_stream_driver;
  localparam int CHAR_W      = 8;
  localparam int POS_W       = 32;
  localparam int FIFO_DEPTH  = 4;
  localparam int ENG_RST_CYC = 2;
  localparam int TIMEOUT     = 8;
  localparam int DEDUP       = 1;
  localparam int ENTRY_W     = 2 * POS_W + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             busy;
  logic             timeoutErr;
  logic [POS_W-1:0] charCount;

  regex_stream_driver_if #(.CHAR_W(CHAR_W), .POS_W(POS_W)) bus ();

  regex_stream_driver #(
    .CHAR_W(CHAR_W), .POS_W(POS_W), .FIFO_DEPTH(FIFO_DEPTH),
    .ENG_RST_CYC(ENG_RST_CYC), .TIMEOUT(TIMEOUT), .DEDUP(DEDUP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy_o(busy),
    .timeout_err_o(timeoutErr),
    .char_count_o(charCount)
  );

  always #5 clk = ~clk;

  int                 compareCount = 0;
  int                 failCount = 0;
  logic [ENTRY_W-1:0] expQ[$];
  bit                 histValid = 1'b0;
  logic [POS_W-1:0]   histStart = '0;
  logic [POS_W-1:0]   histEnd = '0;
  logic [POS_W-1:0]   expCount = '0;
  bit                 expTimeout = 1'b0;
  int                 consumerMode = 0;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".inReady"}, bus.in_ready, 0);
    checkOutput({tag, ".engReset"}, bus.eng_reset, 1);
    checkOutput({tag, ".engChar"}, bus.eng_char, 0);
    checkOutput({tag, ".engLast"}, bus.eng_last, 0);
    checkOutput({tag, ".resValid"}, bus.res_valid, 0);
    checkOutput({tag, ".resHead"}, {bus.res_start, bus.res_end, bus.res_last}, 0);
    checkOutput({tag, ".busy"}, busy, 0);
    checkOutput({tag, ".timeoutErr"}, timeoutErr, 0);
    checkOutput({tag, ".charCount"}, charCount, 0);
  endtask

  // Model: a match is queued unless it repeats the last queued pair within the stream.
  task automatic applyStimulus(input logic [CHAR_W-1:0] c, input bit last, input int delay,
                               input bit match, input logic [POS_W-1:0] s, input logic [POS_W-1:0] e);
    int n;
    bit push;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checkOutput("inReadyWait", bus.in_ready, 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_char  = CHAR_W'($urandom);
    bus.in_last  = 1'($urandom_range(0, 1));
    expCount     = expCount + 1'b1;

    @(negedge clk);
    checkOutput("engChar", bus.eng_char, c);
    checkOutput("engLast", bus.eng_last, last);
    checkOutput("charCountAccept", charCount, expCount);
    n = 0;
    while (bus.eng_reset && n < 50) begin
      n++;
      bus.eng_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checkOutput("engResetCycles", n, ENG_RST_CYC);
    bus.eng_rdy = 1'b0;

    if (delay < 0) begin
      if (last) histValid = 1'b0;
      repeat (TIMEOUT - 1) @(negedge clk);
      checkOutput("errBeforeTimeout", timeoutErr, expTimeout);
      @(negedge clk);
      expTimeout = 1'b1;
      checkOutput("timeoutErr", timeoutErr, 1);
      n = 1;
      while (!bus.in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput("timeoutReadyLatency", n, 2);
    end else begin
      repeat (delay) @(negedge clk);
      bus.eng_rdy   = 1'b1;
      bus.eng_match = match;
      bus.eng_start = s;
      bus.eng_end   = e;
      push = match && !((DEDUP != 0) && histValid && s == histStart && e == histEnd);
      if (push) begin
        expQ.push_back({s, e, last});
        histValid = 1'b1;
        histStart = s;
        histEnd   = e;
      end
      if (last) histValid = 1'b0;
      @(posedge clk);
      #1;
      bus.eng_rdy   = 1'b0;
      bus.eng_match = 1'($urandom_range(0, 1));
      bus.eng_start = $urandom;
      bus.eng_end   = $urandom;
      if (push && consumerMode == 2) begin
        if (last) expCount = '0;
        return;
      end
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.in_ready && n < 400);
      if (!push || consumerMode == 0) checkOutput("readyLatency", n, 3);
      else checkOutput("readyAfterStall", bus.in_ready, 1);
    end
    if (last) expCount = '0;
    checkOutput("charCountEnd", charCount, expCount);
    checkOutput("timeoutSticky", timeoutErr, expTimeout);
  endtask

  task automatic waitDrain(input string tag);
    int n;
    consumerMode = 0;
    n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".pending"}, expQ.size(), 0);
    @(negedge clk);
    checkOutput({tag, ".resValid"}, bus.res_valid, 0);
  endtask

  // Downstream consumer: pops according to consumerMode and scores every popped head.
  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bus.res_ready = 1'b0;
      end else begin
        case (consumerMode)
          0:       bus.res_ready = 1'b1;
          2:       bus.res_ready = 1'b0;
          default: bus.res_ready = 1'($urandom_range(0, 1));
        endcase
        if (bus.res_ready && bus.res_valid) begin
          if (expQ.size() == 0) checkOutput("unexpectedResult", bus.res_valid, 0);
          else checkOutput("resultHead", {bus.res_start, bus.res_end, bus.res_last}, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] global time limit");
  end

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_char   = '0;
    bus.in_last   = 1'b0;
    bus.eng_rdy   = 1'b0;
    bus.eng_match = 1'b0;
    bus.eng_start = '0;
    bus.eng_end   = '0;

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b1;

    consumerMode = 0;
    applyStimulus("a", 1'b1, 3, 1'b1, 0, 0);
    waitDrain("singleChar");

    applyStimulus("a", 1'b0, 1, 1'b0, 0, 0);
    applyStimulus("b", 1'b0, 2, 1'b1, 1, 2);
    applyStimulus("c", 1'b1, 0, 1'b1, 1, 2);
    waitDrain("dedupAbc");

    // Six distinct matches into a four-entry FIFO with the consumer stalled.
    consumerMode = 2;
    for (int i = 0; i < 5; i++) applyStimulus(CHAR_W'(8'h61 + i), 1'b0, i % 3, 1'b1, POS_W'(i), POS_W'(i + 10));
    repeat (10) @(negedge clk);
    checkOutput("stallInReady", bus.in_ready, 0);
    checkOutput("stallBusy", busy, 1);
    checkOutput("stallResValid", bus.res_valid, 1);
    consumerMode = 0;
    applyStimulus("f", 1'b1, 0, 1'b1, 5, 15);
    waitDrain("stallDrain");

    applyStimulus("t", 1'b1, -1, 1'b0, 0, 0);
    applyStimulus("u", 1'b0, TIMEOUT - 1, 1'b1, 3, 4);
    applyStimulus("v", 1'b1, 0, 1'b1, 3, 4);
    waitDrain("timeoutPath");

    applyStimulus("x", 1'b0, 0, 1'b0, 0, 0);
    applyStimulus("y", 1'b0, 0, 1'b0, 0, 0);
    applyStimulus("z", 1'b1, 0, 1'b0, 0, 0);
    applyStimulus("p", 1'b0, 0, 1'b0, 0, 0);
    applyStimulus("q", 1'b1, 0, 1'b0, 0, 0);

    consumerMode = 1;
    for (int i = 0; i < 40; i++) begin
      int d;
      logic [POS_W-1:0] s;
      d = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TIMEOUT - 1);
      s = POS_W'($urandom_range(0, 2));
      applyStimulus(CHAR_W'($urandom), ($urandom_range(0, 4) == 0), d,
                    ($urandom_range(0, 2) != 0), s, s + POS_W'($urandom_range(0, 1)));
    end
    waitDrain("random");

    // Two queued results, then reset lands while a third char waits on the engine.
    consumerMode = 2;
    applyStimulus("g", 1'b0, 0, 1'b1, 20, 21);
    applyStimulus("h", 1'b0, 1, 1'b1, 22, 23);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("preResetReady", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_char  = "r";
    bus.in_last  = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.eng_reset && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("preResetQueued", bus.res_valid, 1);
    checkOutput("preResetBusy", busy, 1);
    reset = 1'b0;
    #1;
    checkResetValues("midReset");
    expQ.delete();
    histValid  = 1'b0;
    expCount   = '0;
    expTimeout = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    consumerMode = 0;
    applyStimulus("s", 1'b1, 0, 1'b1, 5, 6);
    waitDrain("afterReset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule
